// File: rtl/vrf_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : vrf_pkg                                                         |
// | Shared geometry and types of the 16x128 vector register file, plus a     |
// | one-hot to index helper used by the round-robin arbiter.                  |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package vrf_pkg;

  localparam int VRF_DEPTH = 16;
  localparam int VRF_BITS  = 128;
  localparam int VRF_AW    = $clog2(VRF_DEPTH);

  typedef logic [VRF_AW-1:0]   vreg_addr_t;
  typedef logic [VRF_BITS-1:0] vreg_t;

  // Index of the set bit of an up-to-8-bit one-hot vector (0 if none set).
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage : vrf_pkg
`default_nettype wire

// File: rtl/vrf_write_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : vrf_write_arbiter_if                                          |
// | Bundles the requester handshake, issue-stage reservation, flush, VRF     |
// | write port and scoreboard outputs of the VRF write arbiter.               |
// |   master : requesters / issue stage / VRF side (drives requests)          |
// |   slave  : the arbiter itself                                             |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface vrf_write_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 16,
  parameter int BITS  = 128
);
  localparam int c_AW = $clog2(DEPTH);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*c_AW-1:0] req_addr;
  logic [NREQ*BITS-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 reserve_valid;
  logic [c_AW-1:0]      reserve_addr;
  logic                 flush;
  logic                 vrf_writeEn;
  logic [c_AW-1:0]      vrf_addressw;
  logic [BITS-1:0]      vrf_writeData;
  logic [DEPTH-1:0]     busy;
  logic                 reserve_conflict;

  modport master (
    output req_valid, req_addr, req_data, reserve_valid, reserve_addr, flush,
    input  req_ready, vrf_writeEn, vrf_addressw, vrf_writeData, busy, reserve_conflict
  );

  modport slave (
    input  req_valid, req_addr, req_data, reserve_valid, reserve_addr, flush,
    output req_ready, vrf_writeEn, vrf_addressw, vrf_writeData, busy, reserve_conflict
  );

endinterface : vrf_write_arbiter_if
`default_nettype wire

// File: rtl/vrf_write_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_arbiter                                                       |
// | Combinational round-robin arbiter: grants the first requester at or     |
// | after ptr, searching upward with wrap.                                    |
// |   req : request vector        ptr : highest-priority index               |
// |   gnt : one-hot grant         idx : encoded grant (0 when no grant)      |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import vrf_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [7:0] w_oh8;
  logic [2:0] w_idx3;

  always_comb begin : p_gnt
    int  j;
    logic found;
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_oh8        = '0;
    w_oh8[N-1:0] = gnt;
    w_idx3       = onehot2idx(w_oh8);
    idx          = w_idx3[IW-1:0];
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/vrf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : vrf_write_arbiter                                                |
// | Shares the single VRF write port between NREQ producers (round-robin     |
// | valid/ready), registers the winning write one cycle before the VRF port, |
// | and keeps a per-register pending-write scoreboard for hazard stalls.     |
// |   clk, rst : clock, asynchronous active-high reset                        |
// |   bus      : requests, reservations, flush, VRF port, busy, conflict     |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module vrf_write_arbiter
  import vrf_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DEPTH = VRF_DEPTH,
  parameter int BITS  = VRF_BITS
) (
  input  logic               clk,
  input  logic               rst,
  vrf_write_arbiter_if.slave bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [c_IW-1:0]  r_ptr;
  logic             r_wen;
  logic [c_AW-1:0]  r_addr;
  logic [BITS-1:0]  r_data;
  logic [DEPTH-1:0] r_busy;
  logic             r_conflict;

  logic [NREQ-1:0]  w_gnt;
  logic [NREQ-1:0]  w_ready;
  logic [c_IW-1:0]  w_gidx;
  logic             w_hs;
  logic [c_AW-1:0]  w_sel_addr;
  logic [BITS-1:0]  w_sel_data;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_conflict;

  rr_arbiter #(.N(NREQ), .IW(c_IW)) u_rr (
    .req (bus.req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_gidx)
  );

  // Flush and reset both suppress the grant, so no handshake can happen.
  assign w_ready       = (rst || bus.flush) ? '0 : w_gnt;
  assign bus.req_ready = w_ready;
  assign w_hs          = |(bus.req_valid & w_ready);

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = bus.req_addr[i*c_AW +: c_AW];
        w_sel_data = bus.req_data[i*BITS +: BITS];
      end
    end
  end

  // Output pipeline and round-robin pointer. A write to reg 0 completes
  // its handshake but never enables the VRF port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wen <= w_hs && (w_sel_addr != '0);
      if (w_hs) begin
        r_ptr  <= (w_gidx == c_IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
      end
    end
  end

  // Scoreboard: a new reservation wins over a same-cycle commit.
  assign w_busy_nxt[0] = 1'b0;
  for (genvar r = 1; r < DEPTH; r++) begin : g_sb
    assign w_busy_nxt[r] = (bus.reserve_valid && bus.reserve_addr == c_AW'(r))
                         || (r_busy[r] && !(r_wen && r_addr == c_AW'(r)));
  end

  // A reservation that coincides with the commit of the same reg is not a
  // conflict: the previous write lands this cycle.
  assign w_conflict = bus.reserve_valid && (bus.reserve_addr != '0)
                    && r_busy[bus.reserve_addr]
                    && !(r_wen && r_addr == bus.reserve_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else if (bus.flush) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict;
    end
  end

  assign bus.vrf_writeEn      = r_wen;
  assign bus.vrf_addressw     = r_addr;
  assign bus.vrf_writeData    = r_data;
  assign bus.busy             = r_busy;
  assign bus.reserve_conflict = r_conflict;

endmodule : vrf_write_arbiter
`default_nettype wire

// File: tb/tb_vrf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_vrf_write_arbiter                                             |
// | Directed scoreboard bench for vrf_write_arbiter: stimulus pushes the     |
// | expected VRF writes, a negedge monitor pops and compares them.           |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_vrf_write_arbiter;

  localparam int c_NREQ = 3;
  localparam int c_AW   = 4;
  localparam int c_BITS = 128;

  typedef struct packed {
    logic [c_AW-1:0]   a;
    logic [c_BITS-1:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  bit   done;
  wr_t  exp_q[$];

  vrf_write_arbiter_if #(.NREQ(c_NREQ), .DEPTH(16), .BITS(c_BITS)) bus ();

  vrf_write_arbiter #(.NREQ(c_NREQ), .DEPTH(16), .BITS(c_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [127:0] d);
    bus.req_addr[i*c_AW +: c_AW]     = a;
    bus.req_data[i*c_BITS +: c_BITS] = d;
  endtask

  task automatic push(input logic [3:0] a, input logic [127:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every enabled VRF write must match the head of the queue.
  always @(negedge clk) begin
    if (!done && bus.vrf_writeEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {124'd0, bus.vrf_addressw}, 128'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {124'd0, bus.vrf_addressw}, {124'd0, e.a});
        chk("wr_data", bus.vrf_writeData, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] d1, d2, d3, da5, d7, d9, d4, dz;
  logic [2:0]   g_exp[6];

  initial begin
    d1  = {32{4'h1}};
    d2  = {32{4'h2}};
    d3  = {32{4'h3}};
    da5 = {16{8'hA5}};
    d7  = {16{8'h77}};
    d9  = {16{8'h99}};
    d4  = {16{8'h44}};
    dz  = {16{8'h5A}};
    g_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    n_checks = 0;
    n_errors = 0;
    done     = 1'b0;

    rst               = 1'b1;
    bus.req_valid     = 3'b111;
    bus.req_addr      = '0;
    bus.req_data      = '0;
    bus.reserve_valid = 1'b0;
    bus.reserve_addr  = '0;
    bus.flush         = 1'b0;
    #2;
    chk("rst_ready", {125'd0, bus.req_ready}, 128'd0);
    chk("rst_wen", {127'd0, bus.vrf_writeEn}, 128'd0);
    chk("rst_addr", {124'd0, bus.vrf_addressw}, 128'd0);
    chk("rst_data", bus.vrf_writeData, 128'd0);
    chk("rst_busy", {112'd0, bus.busy}, 128'd0);
    chk("rst_conflict", {127'd0, bus.reserve_conflict}, 128'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // All three valid for six cycles from ptr=0.
    set_req(0, 4'd1, d1);
    set_req(1, 4'd2, d2);
    set_req(2, 4'd3, d3);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", {125'd0, bus.req_ready}, {125'd0, g_exp[k]});
      case (k % 3)
        0:       push(4'd1, d1);
        1:       push(4'd2, d2);
        default: push(4'd3, d3);
      endcase
      step();
    end
    bus.req_valid = '0;
    step();
    step();

    // Single requester 1, addr 5.
    set_req(1, 4'd5, da5);
    bus.req_valid = 3'b010;
    #1;
    chk("single_ready", {125'd0, bus.req_ready}, 128'd2);
    push(4'd5, da5);
    step();
    bus.req_valid = '0;
    chk("single_wen", {127'd0, bus.vrf_writeEn}, 128'd1);
    chk("single_addr", {124'd0, bus.vrf_addressw}, 128'd5);
    chk("single_data", bus.vrf_writeData, da5);
    step();
    chk("idle_wen", {127'd0, bus.vrf_writeEn}, 128'd0);
    chk("idle_addr_hold", {124'd0, bus.vrf_addressw}, 128'd5);

    // Reserve 7, then commit a write to 7 (ptr=2 -> req0 wins).
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 4'd7;
    step();
    bus.reserve_valid = 1'b0;
    chk("busy7_set", {127'd0, bus.busy[7]}, 128'd1);
    set_req(0, 4'd7, d7);
    bus.req_valid = 3'b001;
    #1;
    chk("wrap_grant", {125'd0, bus.req_ready}, 128'd1);
    push(4'd7, d7);
    step();
    bus.req_valid = '0;
    chk("busy7_commit_cycle", {127'd0, bus.busy[7]}, 128'd1);
    step();
    chk("busy7_cleared", {127'd0, bus.busy[7]}, 128'd0);
    // Reserve again, then reserve during the commit cycle.
    bus.reserve_valid = 1'b1;
    step();
    bus.reserve_valid = 1'b0;
    bus.req_valid = 3'b001;
    #1;
    chk("grant7b", {125'd0, bus.req_ready}, 128'd1);
    push(4'd7, d7);
    step();
    bus.req_valid     = '0;
    bus.reserve_valid = 1'b1;
    step();
    bus.reserve_valid = 1'b0;
    chk("busy7_set_clear", {127'd0, bus.busy[7]}, 128'd1);
    chk("no_conflict_commit", {127'd0, bus.reserve_conflict}, 128'd0);

    // Reserve 3 twice -> one conflict pulse; reserve 0 ignored.
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 4'd3;
    step();
    chk("busy3_set", {127'd0, bus.busy[3]}, 128'd1);
    chk("conflict_first", {127'd0, bus.reserve_conflict}, 128'd0);
    step();
    bus.reserve_valid = 1'b0;
    chk("conflict_pulse", {127'd0, bus.reserve_conflict}, 128'd1);
    chk("busy3_held", {127'd0, bus.busy[3]}, 128'd1);
    step();
    chk("conflict_drop", {127'd0, bus.reserve_conflict}, 128'd0);
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 4'd0;
    step();
    bus.reserve_valid = 1'b0;
    chk("busy0_zero", {127'd0, bus.busy[0]}, 128'd0);
    chk("conflict_reg0", {127'd0, bus.reserve_conflict}, 128'd0);

    // Write to reg 0 (ptr=1 -> req2 wins): handshake only.
    set_req(2, 4'd0, dz);
    bus.req_valid = 3'b100;
    #1;
    chk("addr0_ready", {125'd0, bus.req_ready}, 128'd4);
    step();
    bus.req_valid = '0;
    chk("addr0_wen", {127'd0, bus.vrf_writeEn}, 128'd0);

    // Fill the scoreboard, then flush with a write on the port.
    for (int r = 1; r < 16; r++) begin
      bus.reserve_valid = 1'b1;
      bus.reserve_addr  = 4'(r);
      step();
    end
    bus.reserve_valid = 1'b0;
    chk("busy_full", {112'd0, bus.busy}, 128'hFFFE);
    set_req(0, 4'd9, d9);
    bus.req_valid = 3'b001;
    #1;
    chk("pre_flush_ready", {125'd0, bus.req_ready}, 128'd1);
    push(4'd9, d9);
    step();
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", {125'd0, bus.req_ready}, 128'd0);
    step();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    chk("flush_busy", {112'd0, bus.busy}, 128'd0);
    chk("flush_wen", {127'd0, bus.vrf_writeEn}, 128'd0);
    chk("flush_conflict", {127'd0, bus.reserve_conflict}, 128'd0);

    // Mid-stream reset with a write staged and a reservation held (ptr=1).
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 4'd5;
    set_req(1, 4'd4, d4);
    bus.req_valid = 3'b010;
    #1;
    chk("mid_ready", {125'd0, bus.req_ready}, 128'd2);
    step();
    bus.reserve_valid = 1'b0;
    chk("mid_staged", {127'd0, bus.vrf_writeEn}, 128'd1);
    chk("mid_busy5", {127'd0, bus.busy[5]}, 128'd1);
    rst = 1'b1;
    #1;
    chk("mrst_wen", {127'd0, bus.vrf_writeEn}, 128'd0);
    chk("mrst_addr", {124'd0, bus.vrf_addressw}, 128'd0);
    chk("mrst_data", bus.vrf_writeData, 128'd0);
    chk("mrst_busy", {112'd0, bus.busy}, 128'd0);
    chk("mrst_ready", {125'd0, bus.req_ready}, 128'd0);
    #1;
    bus.req_valid = '0;
    rst = 1'b0;
    step();
    chk("post_rst_wen", {127'd0, bus.vrf_writeEn}, 128'd0);
    step();
    step();

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vrf_write_arbiter
`default_nettype wire
